shift_issue_queue: RTL and testbench
====================================

Name: shift_issue_queue

Overview:
- Operand buffer directly upstream of the 32-bit shifter. It accepts shift requests from decode through a valid/ready handshake and queues them in a small FIFO.
- The queue head drives the shifter's data_in, shift_ctrl and ctrl_ALUopcode inputs.
- It filters opcodes: only SLL (5'b00100) and SRA (5'b00101) are enqueued. Anything else is flagged and dropped.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CNT_W, 8, width of the saturating illegal-opcode counter

Ports:
- clock  input  1  rising-edge clock
- ctrl_reset_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous queue clear
- in_valid  input  1  request present
- in_ready  output  1  queue can accept
- in_data  input  32  operand to shift
- in_shamt  input  5  shift amount
- in_opcode  input  5  ALU opcode
- out_valid  output  1  head entry valid
- out_ready  input  1  shifter consumes head
- out_data  output  32  to shifter data_in
- out_shamt  output  5  to shifter shift_ctrl
- out_opcode  output  5  to shifter ctrl_ALUopcode
- count  output  $clog2(DEPTH)+1  occupancy
- err_illegal  output  1  one-cycle pulse: non-shift opcode dropped
- illegal_cnt  output  CNT_W  saturating count of dropped requests

Behaviour:
- Interface: one clock, `clock`. Reset `ctrl_reset_n` is asynchronous and active-low.
- Reset (ctrl_reset_n=0, asynchronous), all registers cleared:
  - count=0; read/write pointers=0
  - out_valid=0; out_data/out_shamt/out_opcode=0
  - err_illegal=0; illegal_cnt=0
  - in_ready=1 once reset deasserts
- Reset mid-operation discards all queued entries.
- Handshake signals:
  - in_ready = (count < DEPTH). It depends on count only, so there is no pop-through when full.
  - out_valid = (count != 0).
  - out_* are driven from the head storage entry, with no combinational path from in_*.
- Accept: in_valid & in_ready. Push: accept & legal, where legal = (in_opcode==5'b00100) | (in_opcode==5'b00101).
- Pop: out_valid & out_ready.
- Push and pop in the same cycle: count unchanged; both pointers advance. Allowed at any count from 1 to DEPTH-1.
- Pointers wrap modulo DEPTH.
- Count update: count += push - pop.
- Latency: an entry pushed at edge N is visible on out_* after edge N (earliest pop in cycle N+1).
- Illegal request (accept & ~legal):
  - not stored; in_ready is still honoured, so the request is consumed
  - err_illegal=1 for exactly the next cycle
  - illegal_cnt increments and saturates at 2^CNT_W-1
- Requests are not accepted when full (in_ready=0), so illegal opcodes offered while full are neither counted nor flagged.
- flush=1 at an edge:
  - count and pointers go to 0
  - push and pop in that cycle are ignored
  - illegal detection in that cycle still pulses err_illegal and counts
- Data fields pass unmodified. shamt=0 is legal and queued normally.
- No X propagation: out_* hold their last head value when out_valid=0.

Optional Feature:
- Macro: SHIFT_ISSUE_BYPASS_EN.
- Defined:
  - When count==0 and flush=0, the block drives out_valid=in_valid&legal, and out_data/out_shamt/out_opcode come combinationally from in_*.
  - If out_ready=1 in that cycle, the request is consumed without being stored (count stays 0), giving zero-cycle latency.
  - If out_ready=0, the request is pushed normally.
  - in_ready is unchanged.
- Undefined: minimum latency is 1 cycle as above, and out_* are purely registered.

Test Plan:
- Reset release, then push SLL data=32'h0000_0001, shamt=4, out_ready=0 -> next cycle out_valid=1, out_data=32'h1, out_shamt=4, out_opcode=5'b00100, count=1.
- Push 4 SRA entries (data 32'h8000_0000..32'h8000_0003) with out_ready=0 -> count=4, in_ready=0; 5th offer not accepted. Then out_ready=1 for 4 cycles -> entries emerge in order, count returns to 0, pointers wrap.
- Simultaneous push and pop at count=2 for 6 cycles -> count stays 2, output order preserved across wrap.
- Offer opcode 5'b00000 (ADD) with queue empty -> count stays 0, err_illegal high exactly one cycle, illegal_cnt=1. Repeat 300 times with CNT_W=8 -> illegal_cnt saturates at 255.
- Queue holding 3 entries; assert flush together with in_valid (SLL) and out_ready -> next cycle count=0, out_valid=0, nothing enqueued.
- Assert ctrl_reset_n=0 asynchronously mid-cycle with count=2 -> out_valid and count drop to 0 immediately, without waiting for a clock edge. With SHIFT_ISSUE_BYPASS_EN defined: empty queue, SRA offered with out_ready=1 -> out_valid=1 in the same cycle, count stays 0.

Source files
------------

// File: rtl/shift_issue_queue.sv
// Shift-request issue queue feeding the 32-bit shifter: filters SLL/SRA, buffers up to DEPTH entries.
// Optional zero-latency empty-queue bypass is enabled by defining SHIFT_ISSUE_BYPASS_EN.
module shift_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data,
    input  logic [4:0]                in_shamt,
    input  logic [4:0]                in_opcode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic [4:0]                out_shamt,
    output logic [4:0]                out_opcode,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      err_illegal,
    output logic [CNT_W-1:0]          illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = 42;

    localparam logic [4:0]       OP_SLL   = 5'b00100;
    localparam logic [4:0]       OP_SRA   = 5'b00101;
    localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] ILL_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ILL_MAX  = {CNT_W{1'b1}};

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SRA);
    endfunction

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [ENT_W-1:0] r_head;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_err_illegal;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic [ENT_W-1:0] w_in_entry;
    logic             w_legal;
    logic             w_accept;
    logic             w_illegal;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass_take;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [OCC_W-1:0] w_count_nxt;
    logic [ENT_W-1:0] w_head_nxt;

    assign w_in_entry = {in_data, in_shamt, in_opcode};
    assign w_legal    = is_shift_op(in_opcode);
    assign w_accept   = in_valid && r_in_ready;
    assign w_illegal  = w_accept && !w_legal;
    // flush squashes both queue movements but not illegal-opcode reporting
    assign w_push     = w_accept && w_legal && !flush && !w_bypass_take;
    assign w_pop      = r_out_valid && out_ready && !flush;

    // Next pointers, occupancy and the head entry to present after this edge
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_head_nxt   = r_head;
        if (flush) begin
            w_wr_ptr_nxt = PTR_ZERO;
            w_rd_ptr_nxt = PTR_ZERO;
            w_count_nxt  = OCC_ZERO;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + OCC_ONE;
                2'b01:   w_count_nxt = r_count - OCC_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
        // The slot being written this cycle becomes head only when it lands on the new read pointer
        if (w_count_nxt == OCC_ZERO) begin
            w_head_nxt = r_head;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_in_entry;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Entry storage
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ENT_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Queue state and registered handshake/head outputs
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_count     <= OCC_ZERO;
            r_head      <= {ENT_W{1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_head      <= w_head_nxt;
            r_out_valid <= (w_count_nxt != OCC_ZERO);
            r_in_ready  <= (w_count_nxt < OCC_FULL);
        end
    end

    // Illegal-opcode pulse and saturating drop counter
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_err_illegal <= 1'b0;
            r_illegal_cnt <= {CNT_W{1'b0}};
        end else begin
            r_err_illegal <= w_illegal;
            if (w_illegal && (r_illegal_cnt != ILL_MAX)) begin
                r_illegal_cnt <= r_illegal_cnt + ILL_ONE;
            end
        end
    end

`ifdef SHIFT_ISSUE_BYPASS_EN
    logic w_bypass_path;

    assign w_bypass_path = (r_count == OCC_ZERO) && !flush;
    assign w_bypass_take = w_bypass_path && in_valid && w_legal && out_ready;

    // Empty queue: present the incoming request directly to the shifter
    always_comb begin
        if (w_bypass_path) begin
            out_valid = in_valid && w_legal;
            {out_data, out_shamt, out_opcode} = w_in_entry;
        end else begin
            out_valid = r_out_valid;
            {out_data, out_shamt, out_opcode} = r_head;
        end
    end
`else
    assign w_bypass_take = 1'b0;
    assign out_valid     = r_out_valid;
    assign {out_data, out_shamt, out_opcode} = r_head;
`endif

    assign in_ready    = r_in_ready;
    assign count       = r_count;
    assign err_illegal = r_err_illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed bench for shift_issue_queue: stimulus queues expected head entries, a negedge monitor checks them.
module tb_shift_issue_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_ADD = 5'b00000;

    logic                   clock = 1'b0;
    logic                   ctrl_reset_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_data;
    logic [4:0]             in_shamt;
    logic [4:0]             in_opcode;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_data;
    logic [4:0]             out_shamt;
    logic [4:0]             out_opcode;
    logic [$clog2(DEPTH):0] count;
    logic                   err_illegal;
    logic [CNT_W-1:0]       illegal_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [4:0]  op;
    } ent_t;

    ent_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    shift_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_shamt     (in_shamt),
        .in_opcode    (in_opcode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_shamt    (out_shamt),
        .out_opcode   (out_opcode),
        .count        (count),
        .err_illegal  (err_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [4:0] op);
        in_valid  = v;
        in_data   = d;
        in_shamt  = s;
        in_opcode = op;
    endtask

    // Legal request expected to be accepted: record it for the monitor
    task automatic offer_exp(input logic [31:0] d, input logic [4:0] s, input logic [4:0] op);
        offer(1'b1, d, s, op);
        exp_q.push_back('{data: d, shamt: s, op: op});
    endtask

    // Monitor: every head transfer must match the oldest expected entry
    always @(negedge clock) begin
        if (ctrl_reset_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h with nothing expected", out_data);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("out_data", {32'h0, out_data}, {32'h0, e.data});
                chk("out_shamt", {59'h0, out_shamt}, {59'h0, e.shamt});
                chk("out_opcode", {59'h0, out_opcode}, {59'h0, e.op});
            end
        end
    end

    initial begin
        ctrl_reset_n = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        #12;
        chk("rst_count", {59'h0, count}, 64'd0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_out_data", {32'h0, out_data}, 64'd0);
        chk("rst_err", {63'h0, err_illegal}, 64'd0);
        chk("rst_ill_cnt", {56'h0, illegal_cnt}, 64'd0);
        ctrl_reset_n = 1'b1;
        step();
        chk("rst_in_ready", {63'h0, in_ready}, 64'd1);

        // Single SLL push, one-cycle latency
        offer_exp(32'h0000_0001, 5'd4, OP_SLL);
        step();
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        chk("t1_out_valid", {63'h0, out_valid}, 64'd1);
        chk("t1_out_data", {32'h0, out_data}, 64'h1);
        chk("t1_out_shamt", {59'h0, out_shamt}, 64'd4);
        chk("t1_out_opcode", {59'h0, out_opcode}, 64'd4);
        chk("t1_count", {59'h0, count}, 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drain_count", {59'h0, count}, 64'd0);
        chk("t1_drain_valid", {63'h0, out_valid}, 64'd0);

        // Fill to DEPTH with SRA, then offers while full are not taken
        for (int i = 0; i < 4; i++) begin
            offer_exp(32'h8000_0000 + 32'(i), 5'(i + 1), OP_SRA);
            step();
        end
        chk("t2_full_count", {59'h0, count}, 64'd4);
        chk("t2_full_in_ready", {63'h0, in_ready}, 64'd0);
        offer(1'b1, 32'h8000_0004, 5'd9, OP_SRA);
        step();
        chk("t2_fifth_count", {59'h0, count}, 64'd4);
        offer(1'b1, 32'h1234_5678, 5'd1, OP_ADD);
        step();
        chk("t2_full_illegal_err", {63'h0, err_illegal}, 64'd0);
        chk("t2_full_illegal_cnt", {56'h0, illegal_cnt}, 64'd0);
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        chk("t2_empty_count", {59'h0, count}, 64'd0);
        chk("t2_empty_in_ready", {63'h0, in_ready}, 64'd1);
`ifndef SHIFT_ISSUE_BYPASS_EN
        chk("t2_hold_out_data", {32'h0, out_data}, 64'h8000_0003);
`endif

        // Steady push+pop at count 2 across the pointer wrap, shamt 0 included
        offer_exp(32'hA000_0000, 5'd0, OP_SLL);
        step();
        offer_exp(32'hA000_0001, 5'd31, OP_SRA);
        step();
        chk("t3_pre_count", {59'h0, count}, 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer_exp(32'hA000_0002 + 32'(i), 5'(i), (i % 2 == 0) ? OP_SLL : OP_SRA);
            step();
            chk("t3_count", {59'h0, count}, 64'd2);
        end
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        step();
        step();
        out_ready = 1'b0;
        chk("t3_drain_count", {59'h0, count}, 64'd0);

        // Illegal opcode on empty queue: dropped, one-cycle pulse
        offer(1'b1, 32'hDEAD_BEEF, 5'd3, OP_ADD);
        step();
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        chk("t4_err_pulse", {63'h0, err_illegal}, 64'd1);
        chk("t4_count", {59'h0, count}, 64'd0);
        chk("t4_ill_cnt", {56'h0, illegal_cnt}, 64'd1);
        step();
        chk("t4_err_clear", {63'h0, err_illegal}, 64'd0);

        // Flush with 3 queued, simultaneous push and pop ignored
        for (int i = 0; i < 3; i++) begin
            offer_exp(32'hC000_0000 + 32'(i), 5'(i + 2), OP_SLL);
            step();
        end
        chk("t5_pre_count", {59'h0, count}, 64'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'hC000_00FF, 5'd7, OP_SLL);
        step();
        exp_q.delete();
        out_ready = 1'b0;
        chk("t5_flush_count", {59'h0, count}, 64'd0);
        chk("t5_flush_valid", {63'h0, out_valid}, 64'd0);
        // Illegal request during flush is still reported
        offer(1'b1, 32'h0, 5'd0, 5'b11111);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        chk("t5_flush_err", {63'h0, err_illegal}, 64'd1);
        chk("t5_flush_ill_cnt", {56'h0, illegal_cnt}, 64'd2);
        chk("t5_flush_illegal_count", {59'h0, count}, 64'd0);
        offer_exp(32'h5A5A_A5A5, 5'd17, OP_SRA);
        step();
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 300 more illegal requests: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            offer(1'b1, 32'(i), 5'd0, (i % 2 == 0) ? OP_ADD : 5'b00110);
            step();
        end
        chk("t4_sat_err", {63'h0, err_illegal}, 64'd1);
        chk("t4_sat_cnt", {56'h0, illegal_cnt}, 64'd255);
        chk("t4_sat_queue", {59'h0, count}, 64'd0);
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        step();
        chk("t4_sat_hold", {56'h0, illegal_cnt}, 64'd255);

        // Asynchronous reset mid-cycle with 2 queued
        offer_exp(32'hE000_0000, 5'd5, OP_SLL);
        step();
        offer_exp(32'hE000_0001, 5'd6, OP_SRA);
        step();
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        chk("t6_pre_count", {59'h0, count}, 64'd2);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_async_count", {59'h0, count}, 64'd0);
        chk("t6_async_valid", {63'h0, out_valid}, 64'd0);
        chk("t6_async_ill_cnt", {56'h0, illegal_cnt}, 64'd0);
        #10;
        ctrl_reset_n = 1'b1;
        step();
        chk("t6_post_in_ready", {63'h0, in_ready}, 64'd1);

`ifdef SHIFT_ISSUE_BYPASS_EN
        // Zero-latency bypass on empty queue
        out_ready = 1'b1;
        offer_exp(32'h8765_4321, 5'd12, OP_SRA);
        #1;
        chk("byp_valid", {63'h0, out_valid}, 64'd1);
        step();
        offer(1'b0, 32'h0, 5'd0, 5'd0);
        out_ready = 1'b0;
        chk("byp_count", {59'h0, count}, 64'd0);
`endif

        step();
        chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
